// File: rtl/fp_mult_pkg.sv
// Shared types and widths for the single-precision multiply path.
package fp_mult_pkg;
  localparam int MANT_W = 24;
  localparam int PROD_W = 2 * MANT_W;
  localparam int CNT_W  = $clog2(MANT_W);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } mult_state_t;
endpackage

// File: rtl/csa_row.sv
// One row of 3:2 compressors; the carry vector is pre-shifted and its top bit dropped.
module csa_row #(
  parameter int W = 48
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] s,
  output logic [W-1:0] c
);
  assign s = x ^ y ^ z;

  always_comb begin
    c = '0;
    for (int i = 0; i < W - 1; i++) begin
      c[i+1] = (x[i] & y[i]) | (x[i] & z[i]) | (y[i] & z[i]);
    end
  end
endmodule

// File: rtl/mant_mult_seq.sv
// Iterative mantissa multiplier: one partial product per cycle into a carry-save
// accumulator, a single carry-propagate add, then hold until the consumer takes it.
module mant_mult_seq
  import fp_mult_pkg::*;
#(
  parameter int MW = MANT_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [MW-1:0]   a_mant,
  input  logic [MW-1:0]   b_mant,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*MW-1:0] product,
  output logic            busy
);
  localparam int PW = 2 * MW;
  localparam int CW = $clog2(MW);

  // Handshake: a transfer happens on an edge where valid && ready are both high;
  // in_ready is high only in IDLE and out_valid only in DONE.
  mult_state_t   state, state_next;
  logic [MW-1:0] a_reg, b_reg;
  logic [PW-1:0] sum, carry, pp, csa_s, csa_c, product_reg;
  logic [CW-1:0] cnt;
  logic          operand_zero;
  logic          last_step;

  assign operand_zero = (a_mant == '0) || (b_mant == '0);
  assign last_step    = (cnt == CW'(MW - 1));
  assign pp           = b_reg[cnt] ? (PW'(a_reg) << cnt) : '0;

  csa_row #(.W(PW)) u_csa (
    .x (sum),
    .y (carry),
    .z (pp),
    .s (csa_s),
    .c (csa_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = operand_zero ? DONE : ACCUM;
      ACCUM:   if (last_step) state_next = RESOLVE;
      RESOLVE: state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg       <= '0;
      b_reg       <= '0;
      sum         <= '0;
      carry       <= '0;
      cnt         <= '0;
      product_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a_mant;
            b_reg <= b_mant;
            sum   <= '0;
            carry <= '0;
            cnt   <= '0;
            if (operand_zero) product_reg <= '0;
          end
        end
        ACCUM: begin
          sum   <= csa_s;
          carry <= csa_c;
          cnt   <= cnt + CW'(1);
        end
        // Dropping the carry out of the top bit is safe: the true product fits in PW bits.
        RESOLVE: product_reg <= sum + carry;
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign product   = product_reg;
endmodule

// File: tb/tb_mant_mult_seq.sv
// Self-checking bench for mant_mult_seq: directed corner cases plus throttled random traffic.
module tb_mant_mult_seq;
  localparam int MW = 24;
  localparam int PW = 48;
  localparam int N_RANDOM = 2000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] a_mant;
  logic [MW-1:0] b_mant;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] product;
  logic          busy;

  int checks = 0;
  int failures = 0;
  logic [PW-1:0] exp_q[$];

  mant_mult_seq #(.MW(MW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_mant    (a_mant),
    .b_mant    (b_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] ref_mul(input logic [MW-1:0] a, input logic [MW-1:0] b);
    logic [PW-1:0] wa, wb;
    wa = PW'(a);
    wb = PW'(b);
    return wa * wb;
  endfunction

  function automatic logic [MW-1:0] rand_mant();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return '0;
    if (r < 12) return {1'b1, 23'($urandom)};
    return 24'($urandom);
  endfunction

  // Starts and ends just after a falling edge; leaves the DUT holding its result.
  task automatic run_op(input string name, input logic [MW-1:0] a, input logic [MW-1:0] b,
                        input int exp_lat);
    int lat;
    bit hs_ok;
    logic [PW-1:0] exp_p;
    exp_p = ref_mul(a, b);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready_before got=%b want=1", name, in_ready);
    end
    in_valid = 1'b1;
    a_mant = a;
    b_mant = b;
    @(negedge clk);
    in_valid = 1'b0;
    a_mant = 24'($urandom);
    b_mant = 24'($urandom);
    lat = 1;
    hs_ok = 1'b1;
    while (out_valid !== 1'b1 && lat < 60) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) hs_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != exp_lat) begin
      failures++;
      $display("FAIL %s_latency got=%0d want=%0d", name, lat, exp_lat);
    end
    checks++;
    if (!hs_ok) begin
      failures++;
      $display("FAIL %s_busy_ready got=bad want=in_ready0_busy1", name);
    end
    checks++;
    if (product !== exp_p) begin
      failures++;
      $display("FAIL %s_product got=%h want=%h", name, product, exp_p);
    end
  endtask

  task automatic retire(input string name);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_retire got=ov%b ir%b bz%b want=ov0 ir1 bz0", name, out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a_mant = '0;
    b_mant = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || product !== '0) begin
      failures++;
      $display("FAIL reset_values got=ir%b ov%b bz%b p=%h want=ir1 ov0 bz0 p=0",
               in_ready, out_valid, busy, product);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_pow2();
    run_op("pow2", 24'h800000, 24'h800000, 26);
    checks++;
    if (product !== 48'h400000000000) begin
      failures++;
      $display("FAIL pow2_const got=%h want=400000000000", product);
    end
    retire("pow2");
  endtask

  task automatic test_max();
    run_op("max", 24'hFFFFFF, 24'hFFFFFF, 26);
    checks++;
    if (product !== 48'hFFFFFE000001) begin
      failures++;
      $display("FAIL max_const got=%h want=fffffe000001", product);
    end
    retire("max");
  endtask

  task automatic test_zero();
    run_op("zero", 24'h000000, 24'hABCDEF, 1);
    retire("zero");
    run_op("zero_b", 24'h123456, 24'h000000, 1);
    retire("zero_b");
  endtask

  task automatic test_stall();
    bit ok;
    run_op("stall", 24'hC00000, 24'hA00000, 26);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a_mant = 24'($urandom);
      b_mant = 24'($urandom);
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || product !== 48'h780000000000) ok = 1'b0;
    end
    in_valid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL stall_hold got=ov%b p=%h want=ov1 p=780000000000", out_valid, product);
    end
    retire("stall");
    checks++;
    if (product !== 48'h780000000000) begin
      failures++;
      $display("FAIL stall_product_held got=%h want=780000000000", product);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL stall_no_ghost got=ov%b bz%b want=ov0 bz0", out_valid, busy);
    end
  endtask

  task automatic test_reset_mid();
    bit saw_valid;
    in_valid = 1'b1;
    a_mant = 24'hF0F0F0;
    b_mant = 24'hABCDEF;
    @(negedge clk);
    in_valid = 1'b0;
    saw_valid = 1'b0;
    repeat (11) begin
      @(negedge clk);
      if (out_valid === 1'b1) saw_valid = 1'b1;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || product !== '0) begin
      failures++;
      $display("FAIL midreset_async got=ir%b ov%b bz%b p=%h want=ir1 ov0 bz0 p=0",
               in_ready, out_valid, busy, product);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (out_valid === 1'b1) saw_valid = 1'b1;
    end
    checks++;
    if (saw_valid) begin
      failures++;
      $display("FAIL midreset_no_output got=valid_seen want=none");
    end
    run_op("after_reset", 24'h000003, 24'h000005, 26);
    checks++;
    if (product !== 48'h00000000000F) begin
      failures++;
      $display("FAIL after_reset_const got=%h want=00000000000f", product);
    end
    retire("after_reset");
  endtask

  task automatic drive_random(input int n);
    int guard;
    logic [MW-1:0] a, b;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      a = rand_mant();
      b = rand_mant();
      in_valid = 1'b1;
      a_mant = a;
      b_mant = b;
      guard = 0;
      while (in_ready !== 1'b1 && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 200) begin
        checks++;
        failures++;
        $display("FAIL random_accept_timeout got=in_ready0 want=in_ready1 op=%0d", i);
        in_valid = 1'b0;
        break;
      end
      exp_q.push_back(ref_mul(a, b));
      @(negedge clk);
      in_valid = 1'b0;
      a_mant = 24'($urandom);
      b_mant = 24'($urandom);
    end
  endtask

  task automatic monitor_random(input int n);
    int got;
    int cycles;
    logic [PW-1:0] e;
    got = 0;
    cycles = 0;
    while (got < n && cycles < 90000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL random_unexpected got=%h want=no_output", product);
        end else begin
          e = exp_q.pop_front();
          if (product !== e) begin
            failures++;
            $display("FAIL random_product idx=%0d got=%h want=%h", got, product, e);
          end
        end
        got++;
      end
      @(negedge clk);
      cycles++;
    end
    out_ready = 1'b0;
    checks++;
    if (got != n) begin
      failures++;
      $display("FAIL random_count got=%0d want=%0d", got, n);
    end
  endtask

  task automatic test_random();
    fork
      drive_random(N_RANDOM);
      monitor_random(N_RANDOM);
    join
    repeat (40) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL random_drain got=left%0d ov%b want=left0 ov0", exp_q.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_pow2();
    test_max();
    test_zero();
    test_stall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
